// File: rtl/avmm_rail_ctrl_if.sv
// Avalon-MM command/response bundle between the power-sequencer master and
// the avmm_rail_ctrl slave register bank.
interface avmm_rail_ctrl_if #(
    parameter int unsigned P_ADDRSIZE = 8,
    parameter int unsigned P_DATASIZE = 32
) ();
    logic                  avs_s0_read;
    logic                  avs_s0_write;
    logic                  avs_s0_waitrequest;
    logic [P_ADDRSIZE-1:0] avs_s0_address;
    logic [P_DATASIZE-1:0] avs_s0_writedata;
    logic [P_DATASIZE-1:0] avs_s0_readdata;

    modport master (
        output avs_s0_read,
        output avs_s0_write,
        output avs_s0_address,
        output avs_s0_writedata,
        input  avs_s0_waitrequest,
        input  avs_s0_readdata
    );

    modport slave (
        input  avs_s0_read,
        input  avs_s0_write,
        input  avs_s0_address,
        input  avs_s0_writedata,
        output avs_s0_waitrequest,
        output avs_s0_readdata
    );
endinterface

// File: rtl/avmm_rail_ctrl.sv
// Avalon-MM rail controller: CTRL drives rail enables, STATUS returns synchronized PG,
// per-rail timers latch sticky faults. Define RAIL_FAULT_SHUTDOWN_EN to drop a rail on fault.
module avmm_rail_ctrl #(
    parameter int unsigned P_ADDRSIZE  = 8,
    parameter int unsigned P_DATASIZE  = 32,
    parameter int unsigned P_NUM_RAILS = 4,
    parameter int unsigned P_TIMEOUT   = 1000
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    avmm_rail_ctrl_if.slave        avs,
    output logic [P_NUM_RAILS-1:0] rail_en_o,
    input  logic [P_NUM_RAILS-1:0] rail_pg_i,
    output logic                   fault_any_o
);
    localparam int unsigned TW = $clog2(P_TIMEOUT + 1);
    localparam logic [TW-1:0] TMAX = TW'(P_TIMEOUT);

    localparam logic [P_ADDRSIZE-1:0] A_CTRL   = P_ADDRSIZE'(0);
    localparam logic [P_ADDRSIZE-1:0] A_STATUS = P_ADDRSIZE'(1);
    localparam logic [P_ADDRSIZE-1:0] A_FAULT  = P_ADDRSIZE'(2);
    localparam logic [P_ADDRSIZE-1:0] A_ID     = P_ADDRSIZE'(3);
    localparam logic [P_DATASIZE-1:0] ID_VAL   = P_DATASIZE'(32'h5EC0_0000 | P_NUM_RAILS);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_ACK  = 1'b1
    } state_t;

    state_t                 state_q;
    logic                   waitreq_q;
    logic [P_DATASIZE-1:0]  rdata_q;
    logic                   cmd_we_q;
    logic [P_ADDRSIZE-1:0]  cmd_addr_q;
    logic [P_NUM_RAILS-1:0] cmd_wdata_q;
    logic [P_NUM_RAILS-1:0] ctrl_q;
    logic [P_NUM_RAILS-1:0] fault_q;
    logic                   fault_any_q;
    logic [P_NUM_RAILS-1:0] pg_meta_q;
    logic [P_NUM_RAILS-1:0] pg_sync_q;
    logic [TW-1:0]          timer_q [P_NUM_RAILS];

    logic                   ctrl_wr;
    logic                   fault_wr;
    logic [P_NUM_RAILS-1:0] ctrl_rise;
    logic [P_NUM_RAILS-1:0] fault_w1c;
    logic [P_NUM_RAILS-1:0] fault_set;
    logic [P_NUM_RAILS-1:0] ctrl_d;
    logic [P_NUM_RAILS-1:0] fault_d;
    logic [TW-1:0]          timer_d [P_NUM_RAILS];
    logic [P_DATASIZE-1:0]  rdata_mux;

    always_comb begin
        ctrl_wr   = (state_q == ST_ACK) && cmd_we_q && (cmd_addr_q == A_CTRL);
        fault_wr  = (state_q == ST_ACK) && cmd_we_q && (cmd_addr_q == A_FAULT);
        ctrl_rise = ctrl_wr ? (cmd_wdata_q & ~ctrl_q) : '0;
        fault_w1c = fault_wr ? cmd_wdata_q : '0;
        fault_set = '0;
        for (int unsigned i = 0; i < P_NUM_RAILS; i++) begin
            if (!ctrl_q[i] || pg_sync_q[i] || ctrl_rise[i]) begin
                timer_d[i] = '0;
            end else if (timer_q[i] == TMAX) begin
                timer_d[i] = TMAX;
            end else begin
                timer_d[i] = timer_q[i] + 1'b1;
            end
            // Level-sensitive while saturated, so a W1C cannot clear a fault whose cause persists.
            fault_set[i] = (timer_d[i] == TMAX);
        end
        fault_d = (fault_q & ~fault_w1c) | fault_set;
        ctrl_d  = ctrl_wr ? cmd_wdata_q : ctrl_q;
`ifdef RAIL_FAULT_SHUTDOWN_EN
        ctrl_d  = ctrl_d & ~fault_set;
`endif
    end

    always_comb begin
        rdata_mux = '0;
        case (avs.avs_s0_address)
            A_CTRL:   rdata_mux = P_DATASIZE'(ctrl_q);
            A_STATUS: rdata_mux = P_DATASIZE'(pg_sync_q);
            A_FAULT:  rdata_mux = P_DATASIZE'(fault_q);
            A_ID:     rdata_mux = ID_VAL;
            default:  rdata_mux = '0;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            waitreq_q   <= 1'b1;
            rdata_q     <= '0;
            cmd_we_q    <= 1'b0;
            cmd_addr_q  <= '0;
            cmd_wdata_q <= '0;
            ctrl_q      <= '0;
            fault_q     <= '0;
            fault_any_q <= 1'b0;
            pg_meta_q   <= '0;
            pg_sync_q   <= '0;
            timer_q     <= '{default: '0};
        end else begin
            pg_meta_q   <= rail_pg_i;
            pg_sync_q   <= pg_meta_q;
            timer_q     <= timer_d;
            ctrl_q      <= ctrl_d;
            fault_q     <= fault_d;
            fault_any_q <= |fault_q;
            case (state_q)
                ST_IDLE: begin
                    if (avs.avs_s0_read || avs.avs_s0_write) begin
                        state_q     <= ST_ACK;
                        waitreq_q   <= 1'b0;
                        rdata_q     <= rdata_mux;
                        cmd_we_q    <= avs.avs_s0_write;
                        cmd_addr_q  <= avs.avs_s0_address;
                        cmd_wdata_q <= avs.avs_s0_writedata[P_NUM_RAILS-1:0];
                    end
                end
                ST_ACK: begin
                    state_q   <= ST_IDLE;
                    waitreq_q <= 1'b1;
                end
                default: begin
                    state_q   <= ST_IDLE;
                    waitreq_q <= 1'b1;
                end
            endcase
        end
    end

    assign avs.avs_s0_waitrequest = waitreq_q;
    assign avs.avs_s0_readdata    = rdata_q;
    assign rail_en_o              = ctrl_q;
    assign fault_any_o            = fault_any_q;
endmodule

// File: tb/tb_avmm_rail_ctrl.sv
// Scoreboard bench for avmm_rail_ctrl with a cycle-stamped reference model.
// Build with RAIL_FAULT_SHUTDOWN_EN defined to check the fault-shutdown variant.
module tb_avmm_rail_ctrl;
    localparam int unsigned AW = 8;
    localparam int unsigned DW = 32;
    localparam int unsigned NR = 4;
    localparam int unsigned TO = 10;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [NR-1:0] rail_pg = '0;
    logic [NR-1:0] rail_en;
    logic          fault_any;
    bit            checking = 1'b0;

    avmm_rail_ctrl_if #(.P_ADDRSIZE(AW), .P_DATASIZE(DW)) avs ();

    avmm_rail_ctrl #(
        .P_ADDRSIZE (AW),
        .P_DATASIZE (DW),
        .P_NUM_RAILS(NR),
        .P_TIMEOUT  (TO)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .avs        (avs),
        .rail_en_o  (rail_en),
        .rail_pg_i  (rail_pg),
        .fault_any_o(fault_any)
    );

    always #5 clk = ~clk;

    int unsigned tests = 0;
    int unsigned fails = 0;

    typedef struct {
        bit            chk;
        logic [DW-1:0] data;
        string         name;
    } exp_t;
    exp_t sbq[$];
    exp_t mon_e;

    // Reference model: register contents as seen between clock edges.
    int unsigned   cyc = 0;
    logic [NR-1:0] m_ctrl = '0, m_fault = '0, m_pg1 = '0, m_pg2 = '0;
    logic          m_fault_any = 1'b0;
    int            m_start[NR];
    logic [NR-1:0] m_set, m_w1c;
    bit            m_wr_now;

    bit            m_wr_pend = 1'b0;
    int unsigned   m_wr_edge = 0;
    logic [AW-1:0] m_wr_addr = '0;
    logic [DW-1:0] m_wr_data = '0;

    function automatic logic [DW-1:0] m_read(input logic [AW-1:0] a);
        case (int'(a))
            0:       return DW'(m_ctrl);
            1:       return DW'(m_pg2);
            2:       return DW'(m_fault);
            3:       return DW'(32'h5EC0_0000 | NR);
            default: return '0;
        endcase
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_ctrl      = '0;
            m_fault     = '0;
            m_pg1       = '0;
            m_pg2       = '0;
            m_fault_any = 1'b0;
            for (int i = 0; i < int'(NR); i++) m_start[i] = -1;
        end else begin
            cyc      = cyc + 1;
            m_wr_now = m_wr_pend && (m_wr_edge == cyc);
            m_w1c    = (m_wr_now && m_wr_addr == 2) ? m_wr_data[NR-1:0] : '0;
            m_set    = '0;
            // A rail is "bad" while enabled with PG low; it faults once bad for TO consecutive edges.
            for (int i = 0; i < int'(NR); i++) begin
                if (!m_ctrl[i] || m_pg2[i]) m_start[i] = -1;
                else if (m_start[i] < 0)    m_start[i] = int'(cyc);
                m_set[i] = (m_start[i] >= 0) && (int'(cyc) - m_start[i] + 1 >= int'(TO));
            end
            m_fault_any = |m_fault;
            m_fault     = (m_fault & ~m_w1c) | m_set;
            if (m_wr_now && m_wr_addr == 0) m_ctrl = m_wr_data[NR-1:0];
`ifdef RAIL_FAULT_SHUTDOWN_EN
            m_ctrl = m_ctrl & ~m_set;
`endif
            m_pg2 = m_pg1;
            m_pg1 = rail_pg;
        end
    end

    task automatic check(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (checking && !rst) begin
            check("rail_en", DW'(rail_en), DW'(m_ctrl));
            check("fault_any", DW'(fault_any), DW'(m_fault_any));
            if (!avs.avs_s0_waitrequest) begin
                if (sbq.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_ack: waitrequest low with no access outstanding at %0t", $time);
                end else begin
                    mon_e = sbq.pop_front();
                    if (mon_e.chk) check(mon_e.name, avs.avs_s0_readdata, mon_e.data);
                end
            end
        end
    end

    task automatic issue(input bit rd, input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
        exp_t e;
        @(negedge clk);
        avs.avs_s0_read      = rd;
        avs.avs_s0_write     = wr;
        avs.avs_s0_address   = a;
        avs.avs_s0_writedata = d;
        e.chk  = !wr;
        e.data = m_read(a);
        e.name = $sformatf("rdata_0x%0h", a);
        sbq.push_back(e);
        m_wr_pend = wr;
        m_wr_edge = cyc + 2;
        m_wr_addr = a;
        m_wr_data = d;
    endtask

    task automatic wait_ack();
        int unsigned n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (avs.avs_s0_waitrequest && n < 8);
        if (avs.avs_s0_waitrequest) begin
            tests++;
            fails++;
            $display("FAIL ack_timeout: waitrequest stayed 1, required 0 within 8 cycles");
            sbq.delete();
        end
    endtask

    task automatic xact(input bit rd, input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
        issue(rd, wr, a, d);
        wait_ack();
        avs.avs_s0_read      = 1'b0;
        avs.avs_s0_write     = 1'b0;
        avs.avs_s0_address   = AW'($urandom);
        avs.avs_s0_writedata = $urandom;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        avs.avs_s0_read      = 1'b0;
        avs.avs_s0_write     = 1'b0;
        avs.avs_s0_address   = '0;
        avs.avs_s0_writedata = '0;
        #2 rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_waitrequest", DW'(avs.avs_s0_waitrequest), 1);
        check("rst_readdata", avs.avs_s0_readdata, 0);
        check("rst_rail_en", DW'(rail_en), 0);
        check("rst_fault_any", DW'(fault_any), 0);
        rst = 1'b0;
        checking = 1'b1;

        xact(1'b1, 1'b0, 8'h03, '0);
        xact(1'b1, 1'b0, 8'h07, '0);

        xact(1'b0, 1'b1, 8'h00, 32'h5);
        @(negedge clk);
        check("ctrl_en_latency", DW'(rail_en), 32'h5);
        rail_pg = 4'h5;
        repeat (3) @(negedge clk);
        xact(1'b1, 1'b0, 8'h01, '0);
        xact(1'b1, 1'b0, 8'h02, '0);

        rail_pg = 4'h0;
        xact(1'b0, 1'b1, 8'h00, 32'h1);
        repeat (15) @(negedge clk);
        check("timeout_fault_any", DW'(fault_any), 1);
`ifdef RAIL_FAULT_SHUTDOWN_EN
        check("timeout_rail_en", DW'(rail_en), 0);
`else
        check("timeout_rail_en", DW'(rail_en), 1);
`endif
        xact(1'b1, 1'b0, 8'h02, '0);
        xact(1'b1, 1'b0, 8'h00, '0);

        xact(1'b0, 1'b1, 8'h02, 32'h1);
        xact(1'b1, 1'b0, 8'h02, '0);
        rail_pg = 4'h1;
        repeat (4) @(negedge clk);
        xact(1'b0, 1'b1, 8'h02, 32'h1);
        xact(1'b1, 1'b0, 8'h02, '0);
        repeat (2) @(negedge clk);
        check("clear_fault_any", DW'(fault_any), 0);

        issue(1'b0, 1'b1, 8'h00, 32'hF);
        wait_ack();
        #1;
        rst = 1'b1;
        m_wr_pend = 1'b0;
        #1;
        check("midrst_waitrequest", DW'(avs.avs_s0_waitrequest), 1);
        check("midrst_readdata", avs.avs_s0_readdata, 0);
        check("midrst_rail_en", DW'(rail_en), 0);
        check("midrst_fault_any", DW'(fault_any), 0);
        avs.avs_s0_write = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        xact(1'b1, 1'b0, 8'h00, '0);

        xact(1'b1, 1'b1, 8'h00, 32'h3);
        @(negedge clk);
        check("rw_both_rail_en", DW'(rail_en), 32'h3);
        xact(1'b1, 1'b0, 8'h00, '0);

        for (int k = 0; k < 300; k++) begin
            logic [AW-1:0] a;
            int unsigned   kind;
            kind = $urandom_range(0, 9);
            a = ($urandom_range(0, 4) == 0) ? AW'($urandom) : AW'($urandom_range(0, 3));
            if ($urandom_range(0, 2) == 0) rail_pg = NR'($urandom);
            if (kind < 4)      xact(1'b1, 1'b0, a, '0);
            else if (kind < 8) xact(1'b0, 1'b1, a, $urandom);
            else               xact(1'b1, 1'b1, a, $urandom);
            repeat ($urandom_range(0, 14)) @(negedge clk);
        end

        repeat (4) @(negedge clk);
        check("scoreboard_drained", DW'(sbq.size()), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
